// File: rtl/id_stage_if.sv
// Fetch-to-decode, write-back and ID/EX output bundle for id_stage.
// slave: decode stage side; master: fetch/write-back/execute side.
interface id_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr_in;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [8:0]            ctrl_out;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic [DATA_W-1:0]     imm_ext;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [5:0]            funct_out;
  logic                  illegal;

  modport slave (
    input  in_valid, instr_in,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid,
    output ctrl_out, rs_data, rt_data,
    output imm_ext, rs_addr, rt_addr,
    output rd_addr, funct_out, illegal
  );

  modport master (
    output in_valid, instr_in,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid,
    input  ctrl_out, rs_data, rt_data,
    input  imm_ext, rs_addr, rt_addr,
    input  rd_addr, funct_out, illegal
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: control decode, register file, load-use stall and
// registered ID/EX output. Ports: clk, rst, io (id_stage_if.slave).
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data.
module id_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  io
);
  localparam int NREG = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];

  logic [5:0]            op;
  logic [5:0]            fn;
  logic [4:0]            rs5, rt5, rd5;
  logic [REG_ADDR_W-1:0] rs_a, rt_a, rd_a;
  logic [DATA_W-1:0]     imm_d;
  logic [DATA_W-1:0]     rs_d, rt_d;
  logic [8:0]            ctrl_d;
  logic                  ill_d;
  logic                  rd_rt;
  logic                  is_r, is_lw, is_sw, is_beq;
  logic                  hazard;
  logic                  accept;
  logic                  unused_shamt;

  logic                  out_valid_q;
  logic [8:0]            ctrl_q;
  logic [DATA_W-1:0]     rs_q, rt_q_data, imm_q;
  logic [REG_ADDR_W-1:0] rs_q_addr, rt_q_addr, rd_q_addr;
  logic [5:0]            fn_q;
  logic                  ill_q;

  assign op  = io.instr_in[31:26];
  assign fn  = io.instr_in[5:0];
  assign rs5 = io.instr_in[25:21];
  assign rt5 = io.instr_in[20:16];
  assign rd5 = io.instr_in[15:11];
  assign rs_a = rs5[REG_ADDR_W-1:0];
  assign rt_a = rt5[REG_ADDR_W-1:0];
  assign rd_a = rd5[REG_ADDR_W-1:0];
  assign unused_shamt = ^io.instr_in[10:6];

  assign imm_d = {{(DATA_W-16){io.instr_in[15]}},
                  io.instr_in[15:0]};

  assign is_r = (op == 6'h00) &&
                (fn == 6'h20 || fn == 6'h22 ||
                 fn == 6'h24 || fn == 6'h25 ||
                 fn == 6'h2A);
  assign is_lw  = (op == 6'h23);
  assign is_sw  = (op == 6'h2B);
  assign is_beq = (op == 6'h04);

  always_comb begin
    ctrl_d = 9'h000;
    ill_d  = 1'b0;
    rd_rt  = 1'b0;
    unique case (1'b1)
      is_r: begin
        ctrl_d = 9'h122;
        rd_rt  = 1'b1;
      end
      is_lw:  ctrl_d = 9'h0F0;
      is_sw: begin
        ctrl_d = 9'h088;
        rd_rt  = 1'b1;
      end
      is_beq: begin
        ctrl_d = 9'h005;
        rd_rt  = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

`ifdef ID_WB_BYPASS_EN
  always_comb begin
    rs_d = rf_q[rs_a];
    rt_d = rf_q[rt_a];
    if (io.wb_en && io.wb_addr == rs_a && rs_a != '0)
      rs_d = io.wb_data;
    if (io.wb_en && io.wb_addr == rt_a && rt_a != '0)
      rt_d = io.wb_data;
  end
`else
  assign rs_d = rf_q[rs_a];
  assign rt_d = rf_q[rt_a];
`endif

  // Load in ID/EX whose destination the incoming instruction sources.
  assign hazard = out_valid_q && ctrl_q[4] &&
                  (rt_q_addr != '0) &&
                  ((!ill_d && rs_a == rt_q_addr) ||
                   (rd_rt && rt_a == rt_q_addr));

  assign io.in_ready = (!out_valid_q || io.out_ready) && !hazard;
  assign accept = io.in_valid && io.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (io.wb_en && io.wb_addr != '0) begin
      rf_q[io.wb_addr] <= io.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q_data   <= '0;
      imm_q       <= '0;
      rs_q_addr   <= '0;
      rt_q_addr   <= '0;
      rd_q_addr   <= '0;
      fn_q        <= '0;
      ill_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_d;
      rt_q_data   <= rt_d;
      imm_q       <= imm_d;
      rs_q_addr   <= rs_a;
      rt_q_addr   <= rt_a;
      rd_q_addr   <= rd_a;
      fn_q        <= fn;
      ill_q       <= ill_d;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.ctrl_out  = ctrl_q;
  assign io.rs_data   = rs_q;
  assign io.rt_data   = rt_q_data;
  assign io.imm_ext   = imm_q;
  assign io.rs_addr   = rs_q_addr;
  assign io.rt_addr   = rt_q_addr;
  assign io.rd_addr   = rd_q_addr;
  assign io.funct_out = fn_q;
  assign io.illegal   = ill_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed test of id_stage: decode, operands, load-use bubble,
// back-pressure, reset and the optional write-back bypass.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) io ();

  id_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rt_i(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    io.wb_en   = 1'b1;
    io.wb_addr = a;
    io.wb_data = d;
    @(negedge clk);
    io.wb_en   = 1'b0;
  endtask

  logic [5:0] fns [4];
  logic [31:0] rs_exp;

  initial begin
    fns[0] = 6'h22; fns[1] = 6'h24;
    fns[2] = 6'h25; fns[3] = 6'h2A;
    io.in_valid  = 1'b0;
    io.instr_in  = '0;
    io.wb_en     = 1'b0;
    io.wb_addr   = '0;
    io.wb_data   = '0;
    io.out_ready = 1'b1;

    @(negedge clk);
    chk("rst_valid", 32'(io.out_valid), 0);
    chk("rst_ctrl", 32'(io.ctrl_out), 0);
    chk("rst_rs", io.rs_data, 0);
    chk("rst_imm", io.imm_ext, 0);
    chk("rst_ill", 32'(io.illegal), 0);
    chk("rst_ready", 32'(io.in_ready), 1);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(io.in_ready), 1);
    @(negedge clk);

    wb(5'd5, 32'd20);
    wb(5'd10, 32'd7);
    wb(5'd0, 32'd55);

    io.in_valid = 1'b1;
    io.instr_in = rt_i(5, 10, 11, 6'h20);
    #1 chk("add_ready", 32'(io.in_ready), 1);
    @(negedge clk);
    chk("add_valid", 32'(io.out_valid), 1);
    chk("add_ctrl", 32'(io.ctrl_out), 32'h122);
    chk("add_rs", io.rs_data, 20);
    chk("add_rt", io.rt_data, 7);
    chk("add_rd", 32'(io.rd_addr), 11);
    chk("add_ill", 32'(io.illegal), 0);

    for (int i = 0; i < 4; i++) begin
      io.instr_in = rt_i(10, 5, 3, fns[i]);
      #1 chk("b2b_ready", 32'(io.in_ready), 1);
      @(negedge clk);
      chk("b2b_valid", 32'(io.out_valid), 1);
      chk("b2b_ctrl", 32'(io.ctrl_out), 32'h122);
      chk("b2b_fn", 32'(io.funct_out), 32'(fns[i]));
      chk("b2b_ill", 32'(io.illegal), 0);
    end

    io.instr_in = it_i(6'h23, 0, 5, 16'd20);
    #1 chk("lw_ready", 32'(io.in_ready), 1);
    @(negedge clk);
    chk("lw_ctrl", 32'(io.ctrl_out), 32'h0F0);
    chk("lw_imm", io.imm_ext, 20);
    chk("lw_rt", 32'(io.rt_addr), 5);
    io.instr_in = rt_i(5, 0, 12, 6'h20);
    #1 chk("hz_ready", 32'(io.in_ready), 0);
    @(negedge clk);
    chk("hz_bubble", 32'(io.out_valid), 0);
    chk("hz_ready2", 32'(io.in_ready), 1);
    @(negedge clk);
    chk("hz_add_valid", 32'(io.out_valid), 1);
    chk("hz_add_ctrl", 32'(io.ctrl_out), 32'h122);
    chk("hz_add_rd", 32'(io.rd_addr), 12);
    chk("hz_add_rs", io.rs_data, 20);

    io.instr_in = it_i(6'h23, 0, 0, 16'd4);
    @(negedge clk);
    io.instr_in = rt_i(0, 0, 1, 6'h20);
    #1 chk("lw_r0_nohz", 32'(io.in_ready), 1);
    @(negedge clk);
    chk("r0_rs", io.rs_data, 0);

    io.instr_in = it_i(6'h2B, 0, 11, 16'hFFFC);
    @(negedge clk);
    chk("sw_ctrl", 32'(io.ctrl_out), 32'h088);
    chk("sw_imm", io.imm_ext, 32'hFFFFFFFC);

    io.instr_in = it_i(6'h04, 5, 10, 16'h0002);
    @(negedge clk);
    chk("beq_ctrl", 32'(io.ctrl_out), 32'h005);

    io.instr_in = {6'h3F, 26'd0};
    @(negedge clk);
    chk("ill_ctrl", 32'(io.ctrl_out), 0);
    chk("ill_flag", 32'(io.illegal), 1);
    chk("ill_valid", 32'(io.out_valid), 1);

    io.out_ready = 1'b0;
    io.instr_in = rt_i(10, 5, 3, 6'h20);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 32'(io.in_ready), 0);
      @(negedge clk);
      chk("stall_valid", 32'(io.out_valid), 1);
      chk("stall_ill", 32'(io.illegal), 1);
      chk("stall_ctrl", 32'(io.ctrl_out), 0);
    end
    io.out_ready = 1'b1;
    #1 chk("release_ready", 32'(io.in_ready), 1);
    @(negedge clk);
    chk("release_ctrl", 32'(io.ctrl_out), 32'h122);
    chk("release_rs", io.rs_data, 7);
    chk("release_rt", io.rt_data, 20);
    chk("release_rd", 32'(io.rd_addr), 3);

    io.instr_in = rt_i(5, 10, 13, 6'h20);
    io.wb_en   = 1'b1;
    io.wb_addr = 5'd5;
    io.wb_data = 32'd99;
`ifdef ID_WB_BYPASS_EN
    rs_exp = 32'd99;
`else
    rs_exp = 32'd20;
`endif
    @(negedge clk);
    io.wb_en = 1'b0;
    chk("byp_rs", io.rs_data, rs_exp);
    @(negedge clk);
    chk("wb_after_rs", io.rs_data, 99);

    io.in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(io.out_valid), 0);

    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.instr_in  = it_i(6'h23, 5, 6, 16'd8);
    @(negedge clk);
    chk("pre_rst_valid", 32'(io.out_valid), 1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_valid", 32'(io.out_valid), 0);
    chk("mid_rst_ctrl", 32'(io.ctrl_out), 0);
    chk("mid_rst_ready", 32'(io.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    io.out_ready = 1'b1;
    io.instr_in  = rt_i(5, 10, 14, 6'h20);
    @(negedge clk);
    chk("rf_cleared_rs", io.rs_data, 0);
    chk("rf_cleared_rt", io.rt_data, 0);
    io.in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
